// File: rtl/draw_point_slave_interface.sv
// DrawPoint link to Avalon-MM framebuffer writer.
// Buffers incoming points in a FIFO and writes one RGB444 pixel per point.
module draw_point_slave_interface #(
    parameter int          H_RES      = 320,
    parameter int          V_RES      = 240,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [17:0] FB_BASE    = 18'h00000
) (
    input  logic        csi_clock_clk,
    input  logic        rsi_reset_reset,
    input  logic        coe_dps_ul1Reset_n,
    input  logic        coe_dps_ul1Update,
    input  logic [8:0]  coe_dps_ul9PosX,
    input  logic [8:0]  coe_dps_ul9PosY,
    input  logic [11:0] coe_dps_ul12Rgb12Data,
    output logic [17:0] avm_fb_address,
    output logic        avm_fb_write,
    output logic [15:0] avm_fb_writedata,
    output logic [1:0]  avm_fb_byteenable,
    input  logic        avm_fb_waitrequest,
    output logic [15:0] ul16OverflowCount,
    output logic [15:0] ul16RangeCount,
    output logic        ul1Busy
);

    localparam int          AW    = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CW    = AW + 1;
    localparam logic [31:0] H_LIM = H_RES;
    localparam logic [31:0] V_LIM = V_RES;

    typedef struct packed {
        logic [8:0]  x;
        logic [8:0]  y;
        logic [11:0] rgb;
    } point_t;

    typedef enum logic {
        S_IDLE,
        S_WRITE
    } state_t;

    state_t        state_q;
    state_t        state_d;
    point_t        mem [FIFO_DEPTH];
    point_t        din;
    point_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic        link_ok;
    logic        sample;
    logic        in_range;
    logic        fifo_full;
    logic        fifo_empty;
    logic        push;
    logic        pop;
    logic        range_err;
    logic        ovf_err;
    logic [17:0] head_addr;

    logic        write_d;
    logic [17:0] addr_d;
    logic [15:0] data_d;

    assign link_ok    = coe_dps_ul1Reset_n;
    assign sample     = coe_dps_ul1Update & link_ok;
    assign in_range   = ({23'd0, coe_dps_ul9PosX} < H_LIM) &&
                        ({23'd0, coe_dps_ul9PosY} < V_LIM);
    assign fifo_full  = (count == CW'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);

    // Range errors win over full; the full test uses the registered count.
    assign range_err  = sample & ~in_range;
    assign ovf_err    = sample & in_range & fifo_full;
    assign push       = sample & in_range & ~fifo_full;

    assign din.x   = coe_dps_ul9PosX;
    assign din.y   = coe_dps_ul9PosY;
    assign din.rgb = coe_dps_ul12Rgb12Data;

    assign head      = mem[rd_ptr];
    assign head_addr = FB_BASE
                     + 18'({9'd0, head.y} * 18'(H_RES))
                     + {9'd0, head.x};

    assign avm_fb_byteenable = 2'b11;
    assign ul1Busy           = (count != '0) | avm_fb_write;

    always_comb begin
        state_d = state_q;
        write_d = avm_fb_write;
        addr_d  = avm_fb_address;
        data_d  = avm_fb_writedata;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty && link_ok) begin
                    pop     = 1'b1;
                    addr_d  = head_addr;
                    data_d  = {4'h0, head.rgb};
                    write_d = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!avm_fb_waitrequest) begin
                    if (!fifo_empty && link_ok) begin
                        pop    = 1'b1;
                        addr_d = head_addr;
                        data_d = {4'h0, head.rgb};
                    end else begin
                        write_d = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge csi_clock_clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge csi_clock_clk) begin
        if (rsi_reset_reset) begin
            state_q           <= S_IDLE;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            avm_fb_write      <= 1'b0;
            avm_fb_address    <= '0;
            avm_fb_writedata  <= '0;
            ul16OverflowCount <= '0;
            ul16RangeCount    <= '0;
        end else begin
            state_q          <= state_d;
            avm_fb_write     <= write_d;
            avm_fb_address   <= addr_d;
            avm_fb_writedata <= data_d;
            // A link reset flushes the queue but lets the bus transfer finish.
            if (!link_ok) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
            if (range_err && ul16RangeCount != 16'hFFFF) begin
                ul16RangeCount <= ul16RangeCount + 16'd1;
            end
            if (ovf_err && ul16OverflowCount != 16'hFFFF) begin
                ul16OverflowCount <= ul16OverflowCount + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_draw_point_slave_interface.sv
// Bench for draw_point_slave_interface: vector table, corner sequences
// and random traffic against a queue-based reference model.
module tb_draw_point_slave_interface;

    localparam int H_RES = 320;
    localparam int V_RES = 240;
    localparam int DEPTH = 8;
    localparam int BASE  = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        rstn;
    logic        upd;
    logic [8:0]  px;
    logic [8:0]  py;
    logic [11:0] rgb_i;
    logic        wt;
    logic [17:0] avm_fb_address;
    logic        avm_fb_write;
    logic [15:0] avm_fb_writedata;
    logic [1:0]  avm_fb_byteenable;
    logic [15:0] ovf_cnt;
    logic [15:0] rng_cnt;
    logic        busy;

    draw_point_slave_interface dut (
        .csi_clock_clk         (clk),
        .rsi_reset_reset       (rst),
        .coe_dps_ul1Reset_n    (rstn),
        .coe_dps_ul1Update     (upd),
        .coe_dps_ul9PosX       (px),
        .coe_dps_ul9PosY       (py),
        .coe_dps_ul12Rgb12Data (rgb_i),
        .avm_fb_address        (avm_fb_address),
        .avm_fb_write          (avm_fb_write),
        .avm_fb_writedata      (avm_fb_writedata),
        .avm_fb_byteenable     (avm_fb_byteenable),
        .avm_fb_waitrequest    (wt),
        .ul16OverflowCount     (ovf_cnt),
        .ul16RangeCount        (rng_cnt),
        .ul1Busy               (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int rgb;
    } pt_t;

    typedef struct {
        int x;
        int y;
        int rgb;
        bit exp_w;
        int exp_addr;
        int exp_data;
        int exp_rc;
    } vec_t;

    int  n_checks = 0;
    int  n_errors = 0;
    int  n_acc    = 0;
    int  acc_q[$];
    pt_t m_fifo[$];
    pt_t m_bus;
    bit  m_bus_v;
    int  m_rc;
    int  m_oc;
    vec_t vecs[7];

    function automatic int exp_addr(int x, int y);
        return (BASE + y * H_RES + x) % 262144;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_step(bit u, int x, int y, int c,
                              bit rn, bit w, bit rs);
        int occ;
        bit completes;
        bit do_pop;
        bit do_push;
        pt_t p;
        if (rs) begin
            m_fifo.delete();
            m_bus_v = 1'b0;
            m_rc    = 0;
            m_oc    = 0;
            return;
        end
        occ       = m_fifo.size();
        completes = m_bus_v && !w;
        do_pop    = rn && occ > 0 && (!m_bus_v || !w);
        do_push   = 1'b0;
        if (u && rn) begin
            if (x >= H_RES || y >= V_RES) begin
                if (m_rc < 65535) m_rc++;
            end else if (occ == DEPTH) begin
                if (m_oc < 65535) m_oc++;
            end else begin
                do_push = 1'b1;
            end
        end
        if (do_pop) begin
            m_bus   = m_fifo.pop_front();
            m_bus_v = 1'b1;
        end else if (completes) begin
            m_bus_v = 1'b0;
        end
        if (!rn) m_fifo.delete();
        if (do_push) begin
            p.x = x;
            p.y = y;
            p.rgb = c;
            m_fifo.push_back(p);
        end
    endtask

    task automatic check_model();
        chk("write", int'(avm_fb_write), int'(m_bus_v));
        if (m_bus_v) begin
            chk("address", int'(avm_fb_address), exp_addr(m_bus.x, m_bus.y));
            chk("writedata", int'(avm_fb_writedata), m_bus.rgb);
        end
        chk("busy", int'(busy), int'(m_fifo.size() != 0 || m_bus_v));
        chk("range_count", int'(rng_cnt), m_rc);
        chk("overflow_count", int'(ovf_cnt), m_oc);
        chk("byteenable", int'(avm_fb_byteenable), 3);
    endtask

    // One clock: drive at the falling edge, check at the next falling edge.
    task automatic tick(bit u, int x, int y, int c, bit rn, bit w, bit rs);
        if (avm_fb_write && !w && !rs) begin
            n_acc++;
            acc_q.push_back(int'(avm_fb_address));
        end
        upd   = u;
        px    = 9'(x);
        py    = 9'(y);
        rgb_i = 12'(c);
        rstn  = rn;
        wt    = w;
        rst   = rs;
        model_step(u, x, y, c, rn, w, rs);
        @(negedge clk);
        check_model();
    endtask

    task automatic idle(bit w);
        tick(1'b0, 0, 0, 0, 1'b1, w, 1'b0);
    endtask

    task automatic do_reset();
        tick(1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b1);
        idle(1'b0);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_write"}, int'(avm_fb_write), 0);
        chk({tag, "_addr"}, int'(avm_fb_address), 0);
        chk({tag, "_data"}, int'(avm_fb_writedata), 0);
        chk({tag, "_ovf"}, int'(ovf_cnt), 0);
        chk({tag, "_rng"}, int'(rng_cnt), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        int acc0;
        vecs[0] = '{10,  2,   'hABC, 1'b1, 650,   'h0ABC, 0};
        vecs[1] = '{320, 0,   'h111, 1'b0, 0,     0,      1};
        vecs[2] = '{0,   240, 'h222, 1'b0, 0,     0,      2};
        vecs[3] = '{319, 239, 'hFFF, 1'b1, 76799, 'h0FFF, 2};
        vecs[4] = '{0,   0,   'h123, 1'b1, 0,     'h0123, 2};
        vecs[5] = '{511, 511, 'h333, 1'b0, 0,     0,      3};
        vecs[6] = '{5,   100, 'h456, 1'b1, 32005, 'h0456, 3};

        rst = 1'b1; rstn = 1'b1; upd = 1'b0;
        px = '0; py = '0; rgb_i = '0; wt = 1'b0;
        @(negedge clk);
        tick(1'b1, 3, 3, 'h777, 1'b1, 1'b0, 1'b1);
        chk_zero("reset");
        idle(1'b0);

        // Single points, latency k+2 and one-cycle write.
        foreach (vecs[i]) begin
            tick(1'b1, vecs[i].x, vecs[i].y, vecs[i].rgb, 1'b1, 1'b0, 1'b0);
            idle(1'b0);
            chk("vec_write_k2", int'(avm_fb_write), int'(vecs[i].exp_w));
            if (vecs[i].exp_w) begin
                chk("vec_addr", int'(avm_fb_address), vecs[i].exp_addr);
                chk("vec_data", int'(avm_fb_writedata), vecs[i].exp_data);
            end
            idle(1'b0);
            chk("vec_write_k3", int'(avm_fb_write), 0);
            chk("vec_range", int'(rng_cnt), vecs[i].exp_rc);
        end

        // Backpressure with ten points: one on the bus, eight queued, one lost.
        do_reset();
        for (int i = 0; i < 10; i++) tick(1'b1, i, 1, 'h100 + i, 1'b1, 1'b1, 1'b0);
        chk("bp_overflow", int'(ovf_cnt), 1);
        chk("bp_hold_addr", int'(avm_fb_address), exp_addr(0, 1));
        idle(1'b1);
        idle(1'b1);
        acc0 = n_acc;
        acc_q.delete();
        for (int i = 0; i < 14; i++) idle(1'b0);
        chk("bp_writes", n_acc - acc0, 9);
        for (int i = 0; i < 9; i++) begin
            if (i < acc_q.size()) chk("bp_order", acc_q[i], exp_addr(i, 1));
        end
        chk("bp_busy", int'(busy), 0);

        // Five-cycle stall on a single write.
        do_reset();
        tick(1'b1, 20, 30, 'h9C3, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_write", int'(avm_fb_write), 1);
            chk("stall_addr", int'(avm_fb_address), exp_addr(20, 30));
            chk("stall_data", int'(avm_fb_writedata), 'h9C3);
            idle(1'b1);
        end
        acc0 = n_acc;
        idle(1'b0);
        idle(1'b0);
        chk("stall_accepts", n_acc - acc0, 1);
        chk("stall_after", int'(avm_fb_write), 0);

        // Link reset with a stalled write and three queued points.
        do_reset();
        for (int i = 0; i < 4; i++) tick(1'b1, 40 + i, 7, 'hA0 + i, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 400, 7, 'h0, 1'b0, 1'b1, 1'b0);
        chk("link_write_held", int'(avm_fb_write), 1);
        idle(1'b1);
        acc0 = n_acc;
        for (int i = 0; i < 6; i++) idle(1'b0);
        chk("link_accepts", n_acc - acc0, 1);
        chk("link_write", int'(avm_fb_write), 0);
        chk("link_busy", int'(busy), 0);
        chk("link_rng", int'(rng_cnt), 0);
        chk("link_ovf", int'(ovf_cnt), 0);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            tick(1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 340)),
                 int'($urandom_range(0, 250)),
                 int'($urandom_range(0, 4095)),
                 ($urandom_range(0, 29) != 0),
                 ($urandom_range(0, 9) < 3),
                 1'b0);
        end
        for (int i = 0; i < 20; i++) idle(1'b0);
        chk("rand_drain_busy", int'(busy), 0);

        // Range counter saturation, then a reset in the middle of a write.
        do_reset();
        for (int i = 0; i < 65537; i++) tick(1'b1, 320 + (i % 100), 0, 0, 1'b1, 1'b0, 1'b0);
        chk("sat_range", int'(rng_cnt), 'hFFFF);
        tick(1'b1, 7, 3, 'h5A5, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        chk("midwrite_write", int'(avm_fb_write), 1);
        tick(1'b1, 8, 3, 'h111, 1'b1, 1'b1, 1'b1);
        chk_zero("midreset");
        tick(1'b1, 9, 4, 'h321, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        chk("resume_write", int'(avm_fb_write), 1);
        chk("resume_addr", int'(avm_fb_address), 1289);
        idle(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/draw_point_slave_interface.md
DRAW_POINT_SLAVE_INTERFACE -- requirements
Module: draw_point_si

Interface
- REQ-001: Parameter H_RES, default 320, frame width in pixels.
- REQ-002: Parameter V_RES, default 240, frame height in pixels.
- REQ-003: Parameter FIFO_DEPTH, default 8, point FIFO depth; SHALL be a power of 2, minimum 2.
- REQ-004: Parameter FB_BASE, default 18'h00000, framebuffer word base address.
- REQ-005: The block SHALL have one clock and a synchronous, active-high reset; the ports are csi_clock_clk and rsi_reset_reset.
- REQ-006: Ports (name, direction, width, meaning):
  csi_clock_clk  in  1  clock; the DrawPoint link and framebuffer share this clock.
  rsi_reset_reset  in  1  synchronous active-high reset.
  coe_dps_ul1Reset_n  in  1  DrawPoint link reset, active-low.
  coe_dps_ul1Update  in  1  one-cycle point strobe.
  coe_dps_ul9PosX  in  9  point X.
  coe_dps_ul9PosY  in  9  point Y.
  coe_dps_ul12Rgb12Data  in  12  point colour, RGB444.
  avm_fb_address  out  18  framebuffer word address.
  avm_fb_write  out  1  Avalon-MM write request.
  avm_fb_writedata  out  16  pixel word.
  avm_fb_byteenable  out  2  byte enables.
  avm_fb_waitrequest  in  1  slave stall.
  ul16OverflowCount  out  16  points dropped because the FIFO was full.
  ul16RangeCount  out  16  points dropped because they were out of range.
  ul1Busy  out  1  FIFO not empty, or a write is outstanding.

Function
- REQ-007: Points SHALL be sampled only on a clock edge where coe_dps_ul1Update=1 and coe_dps_ul1Reset_n=1.
- REQ-008: Update high on consecutive cycles SHALL be treated as distinct points.
- REQ-009: Range check: a point with X>=H_RES or Y>=V_RES SHALL be discarded.
  - On discard, ul16RangeCount increments.
  - The range check SHALL take priority over the full check.
- REQ-010: Full check: an in-range point arriving when the registered FIFO count equals FIFO_DEPTH SHALL be discarded, and ul16OverflowCount increments.
  - This applies even if a pop occurs on the same edge.
- REQ-011: Otherwise the point SHALL be pushed as {X, Y, RGB}.
- REQ-012: Both counters SHALL saturate at 16'hFFFF.
- REQ-013: Address SHALL be computed as (FB_BASE + Y*H_RES + X), truncated to 18 bits.
- REQ-014: avm_fb_writedata SHALL be {4'h0, RGB}.
- REQ-015: avm_fb_byteenable SHALL be constant 2'b11.
- REQ-016: Writer FSM states are IDLE and WRITE.
  - IDLE: when the FIFO is not empty, pop the head, register address and data, assert avm_fb_write, and go to WRITE.
  - WRITE: while avm_fb_waitrequest=1, hold address, data and write stable.
  - WRITE, waitrequest=0 and FIFO not empty: the transfer completes; pop the next point and load it on the same edge (back-to-back), staying in WRITE.
  - WRITE, waitrequest=0 and FIFO empty: the transfer completes; deassert write and go to IDLE.
- REQ-017: Latency: a point with update high in cycle k, entering an empty FIFO with the FSM in IDLE, SHALL appear with avm_fb_write=1 in cycle k+2.
- REQ-018: Sustained throughput SHALL be one point per cycle when avm_fb_waitrequest=0.
- REQ-019: Points SHALL be written in arrival order; none are duplicated or reordered.
- REQ-020: coe_dps_ul1Reset_n=0 sampled at an edge SHALL:
  - empty the FIFO at that edge;
  - ignore update;
  - leave the counters unchanged.
  - Any write already asserted SHALL complete per REQ-016 and then go to IDLE.
- REQ-021: Simultaneous push and pop on a non-full FIFO SHALL leave the count unchanged.
- REQ-022: ul1Busy SHALL equal (FIFO count != 0) OR avm_fb_write.

Reset
- REQ-023: On rsi_reset_reset=1 at an edge, the following SHALL apply regardless of any outstanding write:
  - FSM=IDLE, FIFO empty;
  - avm_fb_write=0, avm_fb_address=0, avm_fb_writedata=0;
  - ul16OverflowCount=0, ul16RangeCount=0, ul1Busy=0.
- REQ-024: While rsi_reset_reset=1, update SHALL be ignored.
- REQ-025: Operation SHALL resume on the first edge after reset deasserts.

Verification
- REQ-026: Single point, defaults. X=10, Y=2, RGB=12'hABC in cycle k, waitrequest=0 -> cycle k+2: write=1, address=18'd650, writedata=16'h0ABC; write=0 in k+3.
- REQ-027: Range. X=320, Y=0 -> no write, ul16RangeCount=1. Then X=0, Y=240 -> ul16RangeCount=2.
- REQ-028: Backpressure and overflow.
  - Stimulus: waitrequest held at 1; 10 consecutive in-range points.
  - Required: the first point is held on the bus, 8 points are buffered, ul16OverflowCount=1.
  - After waitrequest releases: exactly 9 writes in order.
- REQ-029: Stall hold. waitrequest=1 for 5 cycles mid-write -> address and data unchanged all 5 cycles, and one write accepted on release.
- REQ-030: Link reset. coe_dps_ul1Reset_n=0 for 1 cycle with 3 points queued and one write stalled -> the stalled write completes, then no further writes; counters unchanged.
- REQ-031: Saturation and reset. Force 65537 range errors -> ul16RangeCount=16'hFFFF. Then rsi_reset_reset pulse mid-write -> all outputs 0 on the next cycle.
